// File: rtl/board_scanner.sv
// Sweeps the board RAM read port in x-inner scan order on each rising edge of start and
// streams one (x, y, colour) plot per cell to the VGA adapter, one cell per clock.
module board_scanner #(
  parameter int X_CELLS    = 160,
  parameter int Y_CELLS    = 120,
  parameter int RD_LATENCY = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  output logic [14:0] rd_address,
  input  logic [2:0]  rd_q,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_e;

  localparam int             FW         = $clog2(RD_LATENCY + 2);
  localparam logic [7:0]     X_LAST     = 8'(X_CELLS - 1);
  localparam logic [6:0]     Y_LAST     = 7'(Y_CELLS - 1);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(RD_LATENCY);

  state_e          state_q, state_d;
  logic            start_q;
  logic [7:0]      x_cnt_q, x_cnt_d;
  logic [6:0]      y_cnt_q, y_cnt_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic            trigger;
  logic            last_cell;

  // Address/valid pipeline that tracks the RAM read latency.
  logic            vld_q  [RD_LATENCY];
  logic [14:0]     addr_q [RD_LATENCY];

  logic [7:0]      x_q;
  logic [6:0]      y_q;
  logic [2:0]      colour_q;
  logic            plot_q;

  assign trigger   = start & ~start_q;
  assign last_cell = (x_cnt_q == X_LAST) && (y_cnt_q == Y_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    flush_d = flush_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_SCAN;
          x_cnt_d = '0;
          y_cnt_d = '0;
        end
      end
      S_SCAN: begin
        if (last_cell) begin
          state_d = S_FLUSH;
          flush_d = '0;
        end else if (x_cnt_q == X_LAST) begin
          x_cnt_d = '0;
          y_cnt_d = y_cnt_q + 7'd1;
        end else begin
          x_cnt_d = x_cnt_q + 8'd1;
        end
      end
      S_FLUSH: begin
        if (flush_q == FLUSH_LAST) state_d = S_DONE;
        else                       flush_d = flush_q + FW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      flush_q <= flush_d;
    end
  end

  // NOTE: the pipeline arrays are cleared on reset so no stale valid bit can emit a plot afterwards.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        addr_q[i] <= '0;
      end
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      vld_q[0]  <= (state_q == S_SCAN);
      addr_q[0] <= {x_cnt_q, y_cnt_q};
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
      plot_q <= vld_q[RD_LATENCY-1];
      if (vld_q[RD_LATENCY-1]) begin
        x_q      <= addr_q[RD_LATENCY-1][14:7];
        y_q      <= addr_q[RD_LATENCY-1][6:0];
        colour_q <= rd_q;
      end
    end
  end

  assign rd_address = {x_cnt_q, y_cnt_q};
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign busy       = (state_q == S_SCAN) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_board_scanner.sv
// Bench for board_scanner: a RAM model with one-cycle read latency and an arithmetic
// reference of the scan order (plot k is cell (k mod X, k div X) at cycle E+3+k).
module tb_board_scanner;

  localparam int XC = 160;
  localparam int YC = 120;
  localparam int NCELLS = XC * YC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [14:0] rd_address;
  logic [2:0]  rd_q;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  board_scanner #(.X_CELLS(XC), .Y_CELLS(YC), .RD_LATENCY(1)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .rd_address(rd_address), .rd_q(rd_q),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [2:0] mem [0:32767];
  always @(posedge clk) rd_q <= mem[rd_address];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor statistics, reset per sweep.
  int sweep_e, plot_k, bad_plots, range_err, dup_err, wrap_err, wraps;
  int busy_cnt, busy_first, busy_last, done_cnt, done_cyc, first_cyc, last_cyc;
  int col57, ex, ey, prev_x, prev_y;
  logic [17:0] first_pl, last_pl;
  bit seen [0:32767];

  task automatic clear_stats();
    plot_k = 0; bad_plots = 0; range_err = 0; dup_err = 0; wrap_err = 0; wraps = 0;
    busy_cnt = 0; busy_first = -1; busy_last = -1; done_cnt = 0; done_cyc = -1;
    first_cyc = -1; last_cyc = -1; col57 = -1; first_pl = '0; last_pl = '0;
    prev_x = 0; prev_y = 0;
    for (int i = 0; i < 32768; i++) seen[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (plot) begin
      ex = plot_k % XC;
      ey = plot_k / XC;
      if (int'(x) != ex || int'(y) != ey || colour !== mem[{8'(ex), 7'(ey)}] ||
          cyc != sweep_e + 3 + plot_k)
        bad_plots++;
      if (int'(x) >= XC || int'(y) >= YC) range_err++;
      else begin
        if (seen[{x, y}]) dup_err++;
        seen[{x, y}] = 1'b1;
      end
      if (plot_k > 0) begin
        if (prev_x == XC - 1) begin
          wraps++;
          if (!(x == 8'd0 && int'(y) == prev_y + 1)) wrap_err++;
        end else if (!(int'(x) == prev_x + 1 && int'(y) == prev_y)) wrap_err++;
      end else begin
        first_pl  = {x, y, colour};
        first_cyc = cyc;
      end
      if (x == 8'd5 && y == 7'd7) col57 = int'(colour);
      last_pl  = {x, y, colour};
      last_cyc = cyc;
      prev_x   = int'(x);
      prev_y   = int'(y);
      plot_k++;
    end
    if (busy) begin
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
      busy_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
  endtask

  // Runs one sweep: start high for `hold` cycles, an extra one-cycle pulse at retrig_off,
  // and optionally a one-cycle reset at reset_off (negative disables either).
  task automatic sweep(input string tag, input int hold, input int retrig_off, input int reset_off);
    int e, limit, plots_at_rst;
    clear_stats();
    plots_at_rst = -1;
    @(negedge clk);
    e = cyc;
    sweep_e = e;
    start = 1'b1;
    limit = (reset_off >= 0) ? reset_off + 21 : NCELLS + 6;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      start = (n < hold) || (n == retrig_off);
      if (n == reset_off) reset = 1'b1;
      if (reset_off >= 0 && n == reset_off + 1) begin
        check({tag, "_rst_plot"}, plot, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_xyc"}, {x, y, colour}, 0);
        check({tag, "_rst_addr"}, rd_address, 0);
        plots_at_rst = plot_k;
        reset = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, "_stream"}, bad_plots, 0);
    check({tag, "_range"}, range_err, 0);
    check({tag, "_dups"}, dup_err, 0);
    check({tag, "_wrap"}, wrap_err, 0);
    if (reset_off >= 0) begin
      check({tag, "_no_plot_after_rst"}, plot_k, plots_at_rst);
      check({tag, "_no_done"}, done_cnt, 0);
      check({tag, "_idle_busy"}, busy, 0);
    end else begin
      check({tag, "_plots"}, plot_k, NCELLS);
      check({tag, "_wraps"}, wraps, YC - 1);
      check({tag, "_first_cyc"}, first_cyc, e + 3);
      check({tag, "_last_cyc"}, last_cyc, e + NCELLS + 2);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_cyc"}, done_cyc, e + NCELLS + 3);
      check({tag, "_busy_cnt"}, busy_cnt, NCELLS + 2);
      check({tag, "_busy_first"}, busy_first, e + 1);
      check({tag, "_busy_last"}, busy_last, e + NCELLS + 2);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'd0;
    clear_stats();
    sweep_e = 0;

    // Reset, then idle with start low.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_outputs", {plot, busy, done, x, y, colour}, 0);
    check("reset_addr", rd_address, 0);
    clear_stats();
    repeat (100) @(negedge clk);
    check("idle_plots", plot_k, 0);
    check("idle_busy", busy_cnt, 0);
    check("idle_done", done_cnt, 0);
    check("idle_addr", rd_address, 0);

    // Long start level plus a retrigger while busy, random board.
    fill_random();
    sweep("long_retrig", 50, 1000, -1);

    // New pulse after done with the preloaded board.
    for (int i = 0; i < 32768; i++) mem[i] = 3'd0;
    mem[{8'd5, 7'd7}]     = 3'b001;
    mem[{8'd159, 7'd119}] = 3'b111;
    repeat (3) @(negedge clk);
    sweep("preload", 1, -1, -1);
    check("preload_first", first_pl, {8'd0, 7'd0, 3'b000});
    check("preload_cell57", col57, 1);
    check("preload_last", last_pl, {8'd159, 7'd119, 3'b111});
    check("hold_addr", rd_address, {8'd159, 7'd119});

    // Reset mid-sweep, then a fresh sweep on a new random board.
    fill_random();
    sweep("mid_reset", 1, -1, 5000);
    fill_random();
    repeat (2) @(negedge clk);
    sweep("fresh", 1 + int'($urandom_range(0, 20)), -1, -1);
    check("fresh_first_xy", first_pl[17:3], 0);

    // Trigger and reset in the same cycle: no sweep.
    clear_stats();
    @(negedge clk);
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("trig_rst_busy", busy_cnt, 0);
    check("trig_rst_plots", plot_k, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
